branch_trainer: RTL
===================

# branch_trainer

Commit-side producer for the branch predictor's training interface and for the mispredict recovery path. Sits between the ROB commit stage and the predictor/fetcher. Accepts committed branch records from the ROB and queues their outcomes for the predictor. Detects mispredictions and issues a registered global flush with a redirect PC, followed by a short recovery window during which commits are held.

## Interface
- TRAIN_DEPTH, 4: training FIFO entries; power of two, ≥2.
- FLUSH_CYCLES, 2: recovery cycles after the flush pulse; ≥1, ≤15.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- rdy  input  1  global enable; when low, all state and outputs hold.
- commit_valid  input  1  ROB presents a committing instruction.
- commit_is_branch  input  1  committing instruction is a conditional branch, JAL or JALR.
- commit_pc  input  32  PC of the committing instruction.
- commit_ins  input  32  raw instruction word.
- commit_taken  input  1  resolved direction.
- commit_pred_taken  input  1  direction predicted at fetch.
- commit_target  input  32  resolved taken target.
- commit_ready  output  1  block accepts a commit this cycle.
- train_en  output  1  training record valid; FIFO head.
- train_jump  output  1  head record's resolved direction.
- train_code  output  32  head record's instruction word.
- train_pc  output  32  head record's PC.
- train_ready  input  1  predictor consumes the head this cycle.
- flush  output  1  one-cycle global flush pulse.
- redirect_pc  output  32  fetch restart PC; valid only while flush=1.

## Operation
- Commit handshake: a commit is accepted when commit_valid && commit_ready && rdy.
- commit_ready = (state==IDLE) && !fifo_full. This is combinational and does not depend on commit_valid.
- Non-branch commits (commit_is_branch=0) are accepted with no effect.
- Accepted branch: enqueue {commit_taken, commit_ins, commit_pc}.
- Mispredict = commit_taken != commit_pred_taken. On mispredict, latch redirect = commit_taken ? commit_target : commit_pc + 4. The add is 32-bit and wraps modulo 2^32.
- FSM states:
  - IDLE: on an accepted mispredicting branch, go to FLUSH.
  - FLUSH: flush=1 and redirect_pc driven for one cycle; then go to RECOVER and load the counter with FLUSH_CYCLES-1.
  - RECOVER: decrement the counter; at 0, go to IDLE.
- FIFO: circular, with read and write pointers plus a count.
  - Dequeue on train_en && train_ready && rdy.
  - Enqueue and dequeue in the same cycle are legal when not full; count is unchanged.
  - Full blocks acceptance through commit_ready. Overflow is impossible by construction.
- Flush never clears the FIFO, because queued records are committed, architecturally valid outcomes. The FIFO keeps draining during FLUSH and RECOVER.
- Reset mid-operation: FIFO emptied, FSM to IDLE, counter cleared, pending flush discarded.

## Timing
- Reset values:
  - commit_ready=1
  - train_en=0; train_jump=0; train_code=0; train_pc=0
  - flush=0; redirect_pc=0
- Training latency: a branch accepted at edge t into an empty FIFO gives train_en=1 in cycle t+1. train_* are driven from registered FIFO storage.
- Flush latency: a mispredicting branch accepted at edge t gives flush=1 in cycle t+1 only.
- commit_ready is low from cycle t+1 through cycle t+1+FLUSH_CYCLES inclusive, and high again at t+2+FLUSH_CYCLES if the FIFO is not full.
- redirect_pc holds its last value when flush=0. Consumers must qualify it with flush.
- rdy low during FLUSH: flush stays asserted and the state is frozen. The pulse spans exactly one rdy-high cycle.
- train_* remain stable while train_en=1 && train_ready=0.

## Configuration
- BRANCH_STATS_EN defined: adds the following ports:
  - stat_branches (output 32): counts accepted branch commits.
  - stat_mispredicts (output 32): counts accepted mispredicting branches.
  - Both reset to 0, increment only when rdy=1, and wrap modulo 2^32.
- BRANCH_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset: assert rst for 2 cycles, then release -> commit_ready=1, train_en=0, flush=0, redirect_pc=0.
- Correct prediction: branch pc=0x100, ins=0x00B50463, taken=1, pred=1 -> next cycle train_en=1, train_pc=0x100, train_jump=1, train_code=0x00B50463; flush stays 0.
- Mispredict not-taken: pc=0xFFFFFFFC, taken=0, pred=1 -> flush=1 for one cycle with redirect_pc=0x00000000 (wrap); commit_ready low for 1+FLUSH_CYCLES=3 cycles.
- Mispredict taken: target=0x2000, taken=1, pred=0 -> redirect_pc=0x2000. With train_ready held 0, the record persists unchanged through FLUSH and RECOVER.
- FIFO full: train_ready=0, commit 4 correct branches -> commit_ready=0 after the 4th. Pulse train_ready for 1 cycle -> one pop; commit_ready=1 the next cycle; record order preserved.
- rdy low mid-FLUSH for 3 cycles -> flush held, counter frozen, no dequeue. With BRANCH_STATS_EN: stat_branches and stat_mispredicts unchanged during the rdy-low window.

Source files
------------

// File: rtl/branch_trainer_if.sv
// Commit and training handshake bundle between the ROB, the
// branch trainer and the predictor/fetcher.
interface branch_trainer_if;
  logic        commit_valid;
  logic        commit_is_branch;
  logic [31:0] commit_pc;
  logic [31:0] commit_ins;
  logic        commit_taken;
  logic        commit_pred_taken;
  logic [31:0] commit_target;
  logic        commit_ready;
  logic        train_en;
  logic        train_jump;
  logic [31:0] train_code;
  logic [31:0] train_pc;
  logic        train_ready;
  logic        flush;
  logic [31:0] redirect_pc;

  modport master (
    output commit_valid,
    output commit_is_branch,
    output commit_pc,
    output commit_ins,
    output commit_taken,
    output commit_pred_taken,
    output commit_target,
    input  commit_ready,
    input  train_en,
    input  train_jump,
    input  train_code,
    input  train_pc,
    output train_ready,
    input  flush,
    input  redirect_pc
  );

  modport slave (
    input  commit_valid,
    input  commit_is_branch,
    input  commit_pc,
    input  commit_ins,
    input  commit_taken,
    input  commit_pred_taken,
    input  commit_target,
    output commit_ready,
    output train_en,
    output train_jump,
    output train_code,
    output train_pc,
    input  train_ready,
    output flush,
    output redirect_pc
  );
endinterface

// File: rtl/branch_trainer.sv
// Commit-side branch training queue and mispredict flush/recovery.
// Optional BRANCH_STATS_EN adds branch/mispredict counters.
module branch_trainer #(
  parameter int TRAIN_DEPTH  = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
`ifdef BRANCH_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  branch_trainer_if.slave bus
);

  localparam int AW = (TRAIN_DEPTH > 1) ? $clog2(TRAIN_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(TRAIN_DEPTH);
  localparam logic [3:0] RCV_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef struct packed {
    logic        jump;
    logic [31:0] code;
    logic [31:0] pc;
  } train_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RECOVER
  } state_t;

  state_t      state;
  logic [3:0]  rcv_cnt;
  logic        flush_q;
  logic [31:0] redirect_q;

  train_rec_t  mem [TRAIN_DEPTH];
  train_rec_t  head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic fifo_full;
  logic fifo_nonempty;
  logic accept;
  logic enq;
  logic deq;
  logic mispredict;
  logic [31:0] redirect_nxt;

  assign fifo_full     = (count == FULL_CNT);
  assign fifo_nonempty = (count != '0);
  assign head          = mem[rd_ptr];

  assign bus.commit_ready = (state == IDLE) && !fifo_full;

  assign accept = bus.commit_valid && bus.commit_ready && rdy;
  assign enq    = accept && bus.commit_is_branch;
  assign deq    = fifo_nonempty && bus.train_ready && rdy;

  assign mispredict   = bus.commit_taken != bus.commit_pred_taken;
  assign redirect_nxt = bus.commit_taken ? bus.commit_target
                                         : bus.commit_pc + 32'd4;

  // Outputs read as zero when empty so stale slots never leak out.
  assign bus.train_en   = fifo_nonempty;
  assign bus.train_jump = fifo_nonempty ? head.jump : 1'b0;
  assign bus.train_code = fifo_nonempty ? head.code : 32'd0;
  assign bus.train_pc   = fifo_nonempty ? head.pc   : 32'd0;

  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_q;

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      mem[wr_ptr] <= '{
        jump: bus.commit_taken,
        code: bus.commit_ins,
        pc:   bus.commit_pc
      };
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        enq && !deq: count <= count + 1'b1;
        !enq && deq: count <= count - 1'b1;
        default:     count <= count;
      endcase
    end
  end

  // Queued records survive flushes: they are committed outcomes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rcv_cnt    <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else if (rdy) begin
      unique case (state)
        IDLE: begin
          if (enq && mispredict) begin
            state      <= FLUSH;
            flush_q    <= 1'b1;
            redirect_q <= redirect_nxt;
          end
        end
        FLUSH: begin
          state   <= RECOVER;
          flush_q <= 1'b0;
          rcv_cnt <= RCV_LOAD;
        end
        RECOVER: begin
          if (rcv_cnt == '0) begin
            state <= IDLE;
          end else begin
            rcv_cnt <= rcv_cnt - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (enq) stat_branches <= stat_branches + 32'd1;
      if (enq && mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule
